multibank_arbiter: RTL and testbench

MULTIBANK_ARBITER -- requirements
Module: multibank_arbiter

---
 rtl/multibank_arbiter.sv | 122 ++++++++++++
 tb/tb_multibank_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multibank_arbiter.sv
// Two-requester arbiter in front of NUM_BANKS single-port SRAM banks.
// Different-bank requests proceed in parallel; same-bank conflicts use round-robin priority.
module multibank_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BANKS  = 2
) (
  input  logic                                        clk,
  input  logic                                        rstb,
  input  logic                                        a_valid,
  input  logic                                        b_valid,
  output logic                                        a_ready,
  output logic                                        b_ready,
  input  logic                                        a_web,
  input  logic                                        b_web,
  input  logic [ADDR_WIDTH-1:0]                       a_addr,
  input  logic [ADDR_WIDTH-1:0]                       b_addr,
  input  logic [DATA_WIDTH-1:0]                       a_din,
  input  logic [DATA_WIDTH-1:0]                       b_din,
  output logic                                        a_rvalid,
  output logic                                        b_rvalid,
  output logic [DATA_WIDTH-1:0]                       a_rdata,
  output logic [DATA_WIDTH-1:0]                       b_rdata,
  output logic [NUM_BANKS-1:0]                        bank_csb,
  output logic [NUM_BANKS-1:0]                        bank_web,
  output logic [NUM_BANKS*(ADDR_WIDTH-$clog2(NUM_BANKS))-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]             bank_din,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]             bank_dout
);

  localparam int BANK_SEL = $clog2(NUM_BANKS);
  localparam int IN_W     = ADDR_WIDTH - BANK_SEL;

  logic [BANK_SEL-1:0]   a_bank, b_bank;
  logic [IN_W-1:0]       a_off, b_off;
  logic                  conflict;
  logic                  a_grant, b_grant;

  logic                  prio_q, prio_d;
  logic                  a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic [BANK_SEL-1:0]   a_pbank_q, b_pbank_q;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  assign a_bank = a_addr[ADDR_WIDTH-1 -: BANK_SEL];
  assign b_bank = b_addr[ADDR_WIDTH-1 -: BANK_SEL];
  assign a_off  = a_addr[IN_W-1:0];
  assign b_off  = b_addr[IN_W-1:0];

  // Grants are masked during reset so no bank is selected while rstb is low.
  always_comb begin
    conflict = a_valid & b_valid & (a_bank == b_bank);
    a_ready  = rstb & (~conflict | ~prio_q);
    b_ready  = rstb & (~conflict | prio_q);
    a_grant  = a_valid & a_ready;
    b_grant  = b_valid & b_ready;
    prio_d   = conflict ? ~prio_q : prio_q;
    a_pend_d = a_grant & a_web;
    b_pend_d = b_grant & b_web;
  end

  always_comb begin
    bank_csb  = '1;
    bank_web  = '1;
    bank_addr = '0;
    bank_din  = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (a_grant && a_bank == BANK_SEL'(k)) begin
        bank_csb[k]                        = 1'b0;
        bank_web[k]                        = a_web;
        bank_addr[k*IN_W +: IN_W]          = a_off;
        bank_din[k*DATA_WIDTH +: DATA_WIDTH] = a_din;
      end
      if (b_grant && b_bank == BANK_SEL'(k)) begin
        bank_csb[k]                        = 1'b0;
        bank_web[k]                        = b_web;
        bank_addr[k*IN_W +: IN_W]          = b_off;
        bank_din[k*DATA_WIDTH +: DATA_WIDTH] = b_din;
      end
    end
  end

  // Capture the bank's output one edge after the access; otherwise hold.
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (a_pend_q && a_pbank_q == BANK_SEL'(k)) a_rdata_d = bank_dout[k*DATA_WIDTH +: DATA_WIDTH];
      if (b_pend_q && b_pbank_q == BANK_SEL'(k)) b_rdata_d = bank_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prio_q     <= 1'b0;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      a_pbank_q  <= '0;
      b_pbank_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      a_pend_q   <= a_pend_d;
      b_pend_q   <= b_pend_d;
      a_pbank_q  <= a_bank;
      b_pbank_q  <= b_bank;
      a_rvalid_q <= a_pend_q;
      b_rvalid_q <= b_pend_q;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_multibank_arbiter.sv
// Directed bench for multibank_arbiter with a two-bank synchronous SRAM model.
module tb_multibank_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        a_valid, b_valid, a_ready, b_ready, a_web, b_web;
  logic [7:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din, a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
  logic [1:0]  bank_csb, bank_web;
  logic [13:0] bank_addr;
  logic [63:0] bank_din, bank_dout;

  int passed = 0;
  int total  = 0;

  // Unwritten locations read as 0xA000_0000 | bank<<8 | offset.
  logic [31:0] mem [2][128];
  bit   [127:0] written [2];
  logic [31:0] dout [2];

  assign bank_dout = {dout[1], dout[0]};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!bank_csb[k]) begin
        if (!bank_web[k]) begin
          mem[k][bank_addr[k*7 +: 7]]     <= bank_din[k*32 +: 32];
          written[k][bank_addr[k*7 +: 7]] <= 1'b1;
        end else if (written[k][bank_addr[k*7 +: 7]]) begin
          dout[k] <= mem[k][bank_addr[k*7 +: 7]];
        end else begin
          dout[k] <= 32'hA000_0000 | (32'(k) << 8) | 32'(bank_addr[k*7 +: 7]);
        end
      end
    end
  end

  multibank_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .NUM_BANKS  (2)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .a_ready   (a_ready),
    .b_ready   (b_ready),
    .a_web     (a_web),
    .b_web     (b_web),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .a_din     (a_din),
    .b_din     (b_din),
    .a_rvalid  (a_rvalid),
    .b_rvalid  (b_rvalid),
    .a_rdata   (a_rdata),
    .b_rdata   (b_rdata),
    .bank_csb  (bank_csb),
    .bank_web  (bank_web),
    .bank_addr (bank_addr),
    .bank_din  (bank_din),
    .bank_dout (bank_dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb = 1'b0;
    a_valid = 1'b1; b_valid = 1'b0; a_web = 1'b1; b_web = 1'b1;
    a_addr = 8'h00; b_addr = 8'h00; a_din = '0; b_din = '0;

    // Reset: valid request must not reach the banks.
    step();
    chk("rst_csb", bank_csb, 2'b11);
    chk("rst_web", bank_web, 2'b11);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
    chk("rst_rdata", {a_rdata, b_rdata}, 64'h0);
    chk("rst_prio", dut.prio_q, 1'b0);
    step();
    rstb = 1'b1;
    a_valid = 1'b0;

    // Parallel reads to different banks.
    a_valid = 1'b1; a_addr = 8'h05;
    b_valid = 1'b1; b_addr = 8'h85;
    #1;
    chk("par_ready", {a_ready, b_ready}, 2'b11);
    chk("par_csb", bank_csb, 2'b00);
    chk("par_web", bank_web, 2'b11);
    chk("par_addr", bank_addr, {7'h05, 7'h05});
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("par_rvalid_n1", {a_rvalid, b_rvalid}, 2'b00);
    step();
    chk("par_rvalid_n2", {a_rvalid, b_rvalid}, 2'b11);
    chk("par_a_rdata", a_rdata, 32'hA000_0005);
    chk("par_b_rdata", b_rdata, 32'hA000_0105);
    step();
    chk("par_rvalid_n3", {a_rvalid, b_rvalid}, 2'b00);
    chk("par_prio", dut.prio_q, 1'b0);

    // Sustained bank1 write conflict alternates A,B,A,B,A,B.
    a_valid = 1'b1; a_web = 1'b0; a_addr = 8'h90; a_din = 32'hAAAA_0001;
    b_valid = 1'b1; b_web = 1'b0; b_addr = 8'hA0; b_din = 32'hBBBB_0001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("alt_ready", {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_addr", bank_addr[13:7], (i % 2 == 0) ? 7'h10 : 7'h20);
      chk("alt_csb", bank_csb, 2'b01);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("alt_prio", dut.prio_q, 1'b0);

    // Same-bank write conflict with prio=0.
    a_valid = 1'b1; a_web = 1'b0; a_addr = 8'h10; a_din = 32'h1111_1111;
    b_valid = 1'b1; b_web = 1'b0; b_addr = 8'h20; b_din = 32'h2222_2222;
    #1;
    chk("cf_ready", {a_ready, b_ready}, 2'b10);
    chk("cf_csb", bank_csb, 2'b10);
    chk("cf_web", bank_web, 2'b10);
    chk("cf_din", bank_din[31:0], 32'h1111_1111);
    step();
    chk("cf_prio1", dut.prio_q, 1'b1);
    a_valid = 1'b0;
    #1;
    chk("cf_b_ready", b_ready, 1'b1);
    chk("cf_b_din", bank_din[31:0], 32'h2222_2222);
    chk("cf_b_addr", bank_addr[6:0], 7'h20);
    step();
    b_valid = 1'b0;
    chk("cf_prio_hold", dut.prio_q, 1'b1);
    chk("cf_no_rvalid", {a_rvalid, b_rvalid}, 2'b00);

    // Back-to-back reads from A with prio=1 (single requester still granted).
    a_valid = 1'b1; a_web = 1'b1; a_addr = 8'h01;
    #1;
    chk("b2b_ready", a_ready, 1'b1);
    step();
    chk("b2b_rv0", a_rvalid, 1'b0);
    a_addr = 8'h02;
    step();
    chk("b2b_rv1", a_rvalid, 1'b1);
    chk("b2b_d1", a_rdata, 32'hA000_0001);
    a_addr = 8'h03;
    step();
    a_valid = 1'b0;
    chk("b2b_rv2", a_rvalid, 1'b1);
    chk("b2b_d2", a_rdata, 32'hA000_0002);
    step();
    chk("b2b_rv3", a_rvalid, 1'b1);
    chk("b2b_d3", a_rdata, 32'hA000_0003);
    step();
    chk("b2b_rv_end", a_rvalid, 1'b0);
    chk("b2b_hold", a_rdata, 32'hA000_0003);

    // Write then read back the same word.
    a_valid = 1'b1; a_web = 1'b0; a_addr = 8'h42; a_din = 32'hDEAD_BEEF;
    step();
    chk("wr_no_rv0", a_rvalid, 1'b0);
    a_web = 1'b1;
    step();
    a_valid = 1'b0;
    chk("wr_no_rv1", a_rvalid, 1'b0);
    step();
    chk("rd_rvalid", a_rvalid, 1'b1);
    chk("rd_data", a_rdata, 32'hDEAD_BEEF);
    step();

    // Reset right after a granted read drops it.
    a_valid = 1'b1; a_web = 1'b1; a_addr = 8'h05;
    step();
    a_valid = 1'b0;
    rstb = 1'b0;
    #1;
    chk("mid_rst_prio", dut.prio_q, 1'b0);
    chk("mid_rst_csb", bank_csb, 2'b11);
    chk("mid_rst_rdata", a_rdata, 32'h0);
    step();
    chk("mid_rst_rvalid", a_rvalid, 1'b0);
    step();
    chk("mid_rst_rvalid2", a_rvalid, 1'b0);

    // First grant in the cycle reset deasserts, prio back to A.
    rstb = 1'b1;
    a_valid = 1'b1; a_web = 1'b1; a_addr = 8'h81;
    b_valid = 1'b1; b_web = 1'b1; b_addr = 8'h82;
    #1;
    chk("post_rst_ready", {a_ready, b_ready}, 2'b10);
    chk("post_rst_csb", bank_csb, 2'b01);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    chk("post_rst_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    chk("post_rst_rdata", a_rdata, 32'hA000_0101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
